// File: rtl/f_accum_max.sv
// f_accum_max: streaming signed running-maximum over a programmable window
// of strideMinusOne+1 samples, with a start delay counted in running cycles.
// out0 shows the running max of the current window and holds the final
// window result until the first sample of the next window overwrites it.
module f_accum_max #(
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      running,
  input  logic        [DELAY_W-1:0] strideMinusOne,
  input  logic        [DELAY_W-1:0] delay0,
  input  logic signed [DATA_W-1:0]  in0,
  output logic signed [DATA_W-1:0]  out0
);

  logic signed [DATA_W-1:0]  acc;
  logic        [DELAY_W-1:0] delay_cnt;
  logic        [DELAY_W-1:0] win_cnt;
  logic        [DELAY_W-1:0] stride_r;
  logic                      accept;
  logic                      win_first;
  logic                      win_last;

  // Two's-complement maximum; ties keep the accumulator value.
  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  assign accept    = running && !run && (delay_cnt == '0);
  assign win_first = (win_cnt == '0);
  assign win_last  = (win_cnt == stride_r);
  assign out0      = acc;

  // Control: configuration latch on run, delay countdown, window position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_cnt <= '0;
      win_cnt   <= '0;
      stride_r  <= '0;
    end else if (run) begin
      delay_cnt <= delay0;
      stride_r  <= strideMinusOne;
      win_cnt   <= '0;
    end else if (running) begin
      if (delay_cnt != '0) begin
        delay_cnt <= delay_cnt - 1'b1;
      end else if (win_last) begin
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

  // Accumulator: first sample of a window loads, later samples take the max.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= win_first ? in0 : smax(acc, in0);
    end
  end

endmodule

// File: tb/tb_f_accum_max.sv
// Directed testbench for f_accum_max with hand-computed expected values.
module tb_f_accum_max;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              running = 1'b0;
  logic        [1:0] strideMinusOne = 2'd0;
  logic        [1:0] delay0 = 2'd0;
  logic signed [7:0] in0 = 8'sd0;
  logic signed [7:0] out0;

  int checks   = 0;
  int failures = 0;

  f_accum_max #(.DATA_W(8), .DELAY_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .running       (running),
    .strideMinusOne(strideMinusOne),
    .delay0        (delay0),
    .in0           (in0),
    .out0          (out0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] expv);
    checks++;
    assert (out0 === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, out0, expv);
    end
  endtask

  task automatic do_run(input logic [1:0] d, input logic [1:0] s);
    run = 1'b1; delay0 = d; strideMinusOne = s;
    step();
    run = 1'b0; delay0 = 2'd0; strideMinusOne = 2'd0;
  endtask

  task automatic sample(input logic [7:0] v, input logic [7:0] expv, input string tag);
    running = 1'b1; in0 = v;
    step();
    check(tag, expv);
  endtask

  initial begin
    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1 check("rst_async", 8'h00);
    #10 rst = 1'b1;
    step(); check("idle0", 8'h00);
    step(); check("idle1", 8'h00);
    step(); check("idle2", 8'h00);

    // Stride 0: pass-through with one cycle latency
    do_run(2'd0, 2'd0);
    check("run_no_sample", 8'h00);
    sample(8'h03, 8'h03, "s0_a");
    sample(8'h05, 8'h05, "s0_b");
    sample(8'h7F, 8'h7F, "s0_c");
    running = 1'b0;

    // Stride 3: window of four, then a new window starts
    do_run(2'd0, 2'd3);
    sample(8'h01, 8'h01, "w4_1");
    sample(8'h07, 8'h07, "w4_2");
    sample(8'h03, 8'h07, "w4_3");
    sample(8'h02, 8'h07, "w4_4");
    sample(8'h04, 8'h04, "w4_new");
    running = 1'b0;

    // Signed comparisons
    do_run(2'd0, 2'd3);
    sample(8'h80, 8'h80, "sg1_1");
    sample(8'hFF, 8'hFF, "sg1_2");
    sample(8'h10, 8'h10, "sg1_3");
    sample(8'h05, 8'h10, "sg1_4");
    sample(8'h80, 8'h80, "sg2_1");
    sample(8'hFE, 8'hFE, "sg2_2");
    sample(8'h90, 8'hFE, "sg2_3");
    sample(8'h81, 8'hFE, "sg2_4");
    running = 1'b0;

    // Start delay of three running cycles
    do_run(2'd3, 2'd0);
    sample(8'hAA, 8'hFE, "dly_1");
    sample(8'hBB, 8'hFE, "dly_2");
    sample(8'hCC, 8'hFE, "dly_3");
    sample(8'h11, 8'h11, "dly_acc");

    // Idle holds state
    running = 1'b0; in0 = 8'h66;
    step(); check("hold", 8'h11);

    // run has priority over running in the same cycle
    running = 1'b1; in0 = 8'h55;
    do_run(2'd0, 2'd3);
    check("run_prio", 8'h11);
    sample(8'h20, 8'h20, "mid_1");
    sample(8'h30, 8'h30, "mid_2");
    running = 1'b0;

    // Asynchronous reset mid-window
    #3 rst = 1'b0;
    #1 check("rst_mid", 8'h00);
    #3 rst = 1'b1;
    step(); check("rst_hold", 8'h00);

    // Without a new run the block behaves as delay 0, stride 0
    sample(8'h44, 8'h44, "post_rst_1");
    sample(8'h33, 8'h33, "post_rst_2");
    running = 1'b0;

    // New window after reset
    do_run(2'd0, 2'd3);
    sample(8'h02, 8'h02, "new_1");
    sample(8'h01, 8'h02, "new_2");
    sample(8'h00, 8'h02, "new_3");
    sample(8'h03, 8'h03, "new_4");
    running = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/f_accum_max.md
Name: f_accum_max

Overview:
- Streaming signed running-maximum unit with a programmable window (stride) and start delay.
- Sits in a datapath and reduces each group of strideMinusOne+1 consecutive samples to their maximum, e.g. for max-pooling.
- out0 is a registered accumulator showing the running max of the current window; it holds the window result until the next window starts.

Parameters:
- DATA_W, 8: sample and accumulator width (two's-complement signed).
- DELAY_W, 2: width of the delay0 and strideMinusOne configuration fields.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- run  input  1  single-cycle start pulse; latches configuration.
- running  input  1  stream active; one input sample per cycle while high.
- strideMinusOne  input  DELAY_W  window length minus one; latched on run.
- delay0  input  DELAY_W  number of running cycles to skip before the first sample; latched on run.
- in0  input  DATA_W  signed input sample.
- out0  output  DATA_W  registered signed accumulator value.

Behaviour:
- State:
  - acc (DATA_W), drives out0 directly.
  - delay_cnt (DELAY_W).
  - win_cnt (DELAY_W).
  - stride_r (DELAY_W).
- Reset (rst=0, asynchronous, no clock needed): acc=0, delay_cnt=0, win_cnt=0, stride_r=0. out0=0 while rst is low.
- run=1 at a clock edge:
  - delay_cnt<=delay0; stride_r<=strideMinusOne; win_cnt<=0.
  - acc is unchanged; in0 is not sampled.
  - run has priority over running in the same cycle.
- running=1, run=0, delay_cnt!=0: delay_cnt<=delay_cnt-1; acc unchanged; in0 ignored.
- running=1, run=0, delay_cnt==0 (accept cycle):
  - If win_cnt==0, acc<=in0 (new window starts; previous result is overwritten).
  - Otherwise acc<=signed max(acc,in0).
  - If win_cnt==stride_r, win_cnt<=0; otherwise win_cnt<=win_cnt+1.
- running=0 and run=0: all state held.
- Latency: an accepted sample affects out0 one cycle after its accept edge.
- Comparison is two's-complement signed. On equal values acc keeps the same value. No saturation; the result is always one of the inputs.
- stride_r=0: every accepted sample passes straight through (out0 equals the previous accepted in0).
- Maximum configuration (DELAY_W bits all ones): delay of 2^DELAY_W-1 cycles, window of 2^DELAY_W samples. win_cnt wraps to 0 without overflow.
- Configuration inputs are ignored except on run cycles.
- Reset mid-window discards the partial window. After reset, a new run is required for nonzero delay/stride; otherwise the block behaves as delay=0, stride=0.

Test Plan:
- Assert rst=0 asynchronously between edges -> out0=0x00 immediately. Release, idle 3 cycles -> out0 stays 0x00.
- run with delay0=0, strideMinusOne=0, then running with in0=0x03,0x05,0x7F -> out0 reads 0x03,0x05,0x7F one cycle after each accept.
- run with delay0=0, strideMinusOne=3, then in0=0x01,0x07,0x03,0x02,0x04 -> out0 after 4th accept=0x07; after 5th accept=0x04 (new window).
- Signed checks with strideMinusOne=3:
  - in0=0x80,0xFF,0x10,0x05 -> out0=0x10.
  - in0=0x80,0xFE,0x90,0x81 -> out0=0xFE.
- run with delay0=3, strideMinusOne=0, then running with in0=0xAA,0xBB,0xCC,0x11 -> out0 unchanged for 3 cycles, then 0x11.
- Pulse rst low mid-window (strideMinusOne=3, 2 samples in) -> out0=0x00 at once. New run with stride 3 and in0=0x02,0x01,0x00,0x03 -> out0 after 4th accept=0x03.
